// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared types and encodings for the multicycle MIPS control unit.
//            Provides opcode constants, the controller state enum, fault
//            codes, datapath mux encodings and a wait-state helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    // Opcode field of the instruction register
    typedef logic [5:0] opcode_type;

    localparam opcode_type OP_RTYPE = 6'b000000;
    localparam opcode_type OP_J     = 6'b000010;
    localparam opcode_type OP_BEQ   = 6'b000100;
    localparam opcode_type OP_BNE   = 6'b000101;
    localparam opcode_type OP_LW    = 6'b100011;
    localparam opcode_type OP_SW    = 6'b101011;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_BNE    = 4'd10,
        S_FAULT  = 4'd11
    } ctrl_state_type;

    // Sticky fault cause
    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_code_type;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SHL = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory ready handshake
    function automatic logic is_wait_state(input ctrl_state_type s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Saturating count of consecutive memory not-ready cycles.
//            'expired' is high once MEM_TIMEOUT not-ready cycles have been
//            counted; with MEM_TIMEOUT = 0 the timer is absent and 'expired'
//            is tied low.
// Ports    : clk, rst (async, active-high)
//            clear   - restart the count (has priority over enable)
//            enable  - count this cycle
//            expired - count has reached MEM_TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

            logic [CW-1:0] count;

            // Saturates at LIMIT so a long stall can never wrap back to zero
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != LIMIT)) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == LIMIT);
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle MIPS control FSM. Sequences each instruction over
//            3-5 states, stalls on memReady, flags illegal opcodes and
//            memory timeouts, and counts retired instructions.
// Ports    : clk, rst (async, active-high), op (IR opcode), memReady
//            Datapath controls: pcWrite, pcWriteCond, branchNe, iorD,
//            memRead, memWrite, irWrite, memToReg, regDst, regWrite,
//            aluSrcA, aluSrcB, aluOp, pcSrc
//            Status: fault, faultCode, instrCount
// Config   : MULTICYCLE_CTRL_BNE_EN - when defined, BNE is a legal
//            instruction and drives branchNe; otherwise BNE faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  opcode_type       op,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             branchNe,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSrc,
    output logic             fault,
    output logic [1:0]       faultCode,
    output logic [CNT_W-1:0] instrCount
);

    ctrl_state_type   state;
    ctrl_state_type   next_state;
    fault_code_type   fault_code;
    fault_code_type   next_fault;
    logic [CNT_W-1:0] instr_count;
    logic             retire;
    logic             wait_expired;

    // Ungated strobe values straight from the state decode
    logic pc_write;
    logic pc_write_cond;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic reg_write;

    logic       ior_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
`ifdef MULTICYCLE_CTRL_BNE_EN
    logic       branch_ne;
`endif

    // ------------------------------------------------------------------
    // Wait timer: counts not-ready cycles in the current wait state and
    // restarts on every state change.
    // ------------------------------------------------------------------
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (next_state != state),
        .enable  (is_wait_state(state) && !memReady),
        .expired (wait_expired)
    );

    // ------------------------------------------------------------------
    // State, fault and retire-count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            fault_code  <= FAULT_NONE;
            instr_count <= '0;
        end else begin
            state <= next_state;
            // Only the entry into FAULT records a cause; FAULT is terminal
            if ((next_state == S_FAULT) && (state != S_FAULT)) begin
                fault_code <= next_fault;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        next_fault    = FAULT_NONE;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        ior_d         = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUSRCB_B;
        alu_op        = ALUOP_ADD;
        pc_src        = PCSRC_ALU;
`ifdef MULTICYCLE_CTRL_BNE_EN
        branch_ne     = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                // A ready on the expiry cycle still completes the fetch
                if (memReady) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (wait_expired) begin
                    next_state = S_FAULT;
                    next_fault = FAULT_TIMEOUT;
                end
            end

            S_DECODE: begin
                alu_src_b = ALUSRCB_IMM_SHL;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_J:         next_state = S_JMP;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       next_state = S_BNE;
`endif
                    default: begin
                        next_state = S_FAULT;
                        next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUSRCB_IMM;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (memReady) begin
                    next_state = S_MEMWB;
                end else if (wait_expired) begin
                    next_state = S_FAULT;
                    next_fault = FAULT_TIMEOUT;
                end
            end

            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end

            S_MEMWR: begin
                // Address (iorD) and request held until memory accepts
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (memReady) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end else if (wait_expired) begin
                    next_state = S_FAULT;
                    next_fault = FAULT_TIMEOUT;
                end
            end

            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUSRCB_B;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end

            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end

            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALUSRCB_B;
                alu_op        = ALUOP_SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                next_state    = S_FETCH;
                retire        = 1'b1;
            end

`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNE: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALUSRCB_B;
                alu_op        = ALUOP_SUB;
                pc_src        = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                branch_ne     = 1'b1;
                next_state    = S_FETCH;
                retire        = 1'b1;
            end
`endif

            S_JMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end

            S_FAULT: begin
                next_state = S_FAULT;
            end

            default: begin
                // Unreachable encodings land in FAULT rather than wander
                next_state = S_FAULT;
                next_fault = FAULT_ILLEGAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are gated by rst combinationally so nothing is
    // requested in the same cycle reset rises.
    // ------------------------------------------------------------------
    assign pcWrite     = pc_write      & ~rst;
    assign pcWriteCond = pc_write_cond & ~rst;
    assign memRead     = mem_read      & ~rst;
    assign memWrite    = mem_write     & ~rst;
    assign irWrite     = ir_write      & ~rst;
    assign regWrite    = reg_write     & ~rst;

    assign iorD     = ior_d;
    assign memToReg = mem_to_reg;
    assign regDst   = reg_dst;
    assign aluSrcA  = alu_src_a;
    assign aluSrcB  = alu_src_b;
    assign aluOp    = alu_op;
    assign pcSrc    = pc_src;

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign branchNe = branch_ne;
`else
    assign branchNe = 1'b0;
`endif

    assign fault      = (state == S_FAULT);
    assign faultCode  = fault_code;
    assign instrCount = instr_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control with
//            MEM_TIMEOUT = 4 and a 4-bit retire counter (so wrap is cheap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic             clk;
    logic             rst;
    opcode_type       op;
    logic             memReady;
    logic             pcWrite;
    logic             pcWriteCond;
    logic             branchNe;
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             irWrite;
    logic             memToReg;
    logic             regDst;
    logic             regWrite;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       aluOp;
    logic [1:0]       pcSrc;
    logic             fault;
    logic [1:0]       faultCode;
    logic [CNT_W-1:0] instrCount;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_control #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .branchNe    (branchNe),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSrc       (pcSrc),
        .fault       (fault),
        .faultCode   (faultCode),
        .instrCount  (instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output signature, MSB first:
    // pcWrite pcWriteCond branchNe iorD memRead memWrite irWrite memToReg
    // regDst regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSrc[1:0]
    logic [16:0] sig;
    assign sig = {pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite,
                  irWrite, memToReg, regDst, regWrite, aluSrcA,
                  aluSrcB, aluOp, pcSrc};

    //                                  pw   pwc  bne  iod  mr   mw   irw  m2r  rd   rw   asa  asb    aop    psrc
    localparam logic [16:0] E_RST    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [16:0] E_FETCH  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [16:0] E_FETCHR = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00};
    localparam logic [16:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00};
    localparam logic [16:0] E_MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00};
    localparam logic [16:0] E_MRD    = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam logic [16:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam logic [16:0] E_MWR    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
    localparam logic [16:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00};
    localparam logic [16:0] E_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00};
    localparam logic [16:0] E_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
    localparam logic [16:0] E_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10};
    localparam logic [16:0] E_FLT    = 17'h0;
`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam logic [16:0] E_BNE    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs just after a rising edge, check mid-cycle, then advance
    task automatic cyc(input opcode_type o, input logic rdy, input logic [16:0] exp, input string tag);
        op       = o;
        memReady = rdy;
        #4;
        check(tag, 32'(sig), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        memReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Guard against a runaway simulation
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        op       = OP_RTYPE;
        memReady = 1'b0;
        #3;
        check("rst_sig",   32'(sig),        32'(E_RST));
        check("rst_fault", 32'(fault),      32'd0);
        check("rst_code",  32'(faultCode),  32'd0);
        check("rst_cnt",   32'(instrCount), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LW, zero wait states: 5 cycles
        cyc(OP_LW, 1'b1, E_FETCHR, "lw_fetch");
        cyc(OP_LW, 1'b1, E_DEC,    "lw_dec");
        cyc(OP_LW, 1'b1, E_MADR,   "lw_madr");
        cyc(OP_LW, 1'b1, E_MRD,    "lw_mrd");
        cyc(OP_LW, 1'b1, E_MWB,    "lw_mwb");
        check("lw_cnt", 32'(instrCount), 32'd1);

        // SW with three not-ready cycles in MEMWR
        cyc(OP_SW, 1'b1, E_FETCHR, "sw_fetch");
        cyc(OP_SW, 1'b1, E_DEC,    "sw_dec");
        cyc(OP_SW, 1'b1, E_MADR,   "sw_madr");
        for (int i = 0; i < 3; i++) cyc(OP_SW, 1'b0, E_MWR, "sw_wait");
        cyc(OP_SW, 1'b1, E_MWR, "sw_ready");
        check("sw_cnt",   32'(instrCount), 32'd2);
        check("sw_fault", 32'(fault),      32'd0);

        // Ready arriving on the expiry cycle still completes the fetch
        for (int i = 0; i < 4; i++) cyc(OP_J, 1'b0, E_FETCH, "edge_wait");
        cyc(OP_J, 1'b1, E_FETCHR, "edge_ready");
        cyc(OP_J, 1'b1, E_DEC,    "edge_dec");
        cyc(OP_J, 1'b1, E_JMP,    "edge_jmp");
        check("edge_cnt",   32'(instrCount), 32'd3);
        check("edge_fault", 32'(fault),      32'd0);

        // R-type, BEQ, J from reset
        do_reset();
        cyc(OP_RTYPE, 1'b1, E_FETCHR, "r_fetch");
        cyc(OP_RTYPE, 1'b1, E_DEC,    "r_dec");
        cyc(OP_RTYPE, 1'b1, E_EXEC,   "r_exec");
        cyc(OP_RTYPE, 1'b1, E_AWB,    "r_awb");
        cyc(OP_BEQ,   1'b1, E_FETCHR, "beq_fetch");
        cyc(OP_BEQ,   1'b1, E_DEC,    "beq_dec");
        cyc(OP_BEQ,   1'b1, E_BEQ,    "beq_exec");
        cyc(OP_J,     1'b1, E_FETCHR, "j_fetch");
        cyc(OP_J,     1'b1, E_DEC,    "j_dec");
        cyc(OP_J,     1'b1, E_JMP,    "j_jmp");
        check("seq_cnt", 32'(instrCount), 32'd3);

        // Reset during a MEMRD stall aborts with strobes dropping at once
        cyc(OP_LW, 1'b1, E_FETCHR, "ab_fetch");
        cyc(OP_LW, 1'b1, E_DEC,    "ab_dec");
        cyc(OP_LW, 1'b1, E_MADR,   "ab_madr");
        cyc(OP_LW, 1'b0, E_MRD,    "ab_mrd");
        rst = 1'b1;
        #1;
        check("ab_rst_sig", 32'(sig),        32'(E_RST));
        check("ab_rst_cnt", 32'(instrCount), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(OP_LW, 1'b0, E_FETCH, "ab_refetch");

        // Fetch timeout: four tolerated not-ready cycles, the fifth faults
        do_reset();
        for (int i = 0; i < 5; i++) cyc(OP_RTYPE, 1'b0, E_FETCH, "to_wait");
        cyc(OP_RTYPE, 1'b1, E_FLT, "to_fault_sig");
        check("to_fault", 32'(fault),     32'd1);
        check("to_code",  32'(faultCode), 32'd2);
        cyc(OP_RTYPE, 1'b1, E_FLT, "to_sticky");
        do_reset();
        check("to_clr_fault", 32'(fault),     32'd0);
        check("to_clr_code",  32'(faultCode), 32'd0);
        cyc(OP_RTYPE, 1'b0, E_FETCH, "to_clr_fetch");

        // Illegal opcode
        do_reset();
        cyc(6'b111111, 1'b1, E_FETCHR, "ill_fetch");
        cyc(6'b111111, 1'b1, E_DEC,    "ill_dec");
        cyc(6'b111111, 1'b1, E_FLT,    "ill_flt");
        cyc(OP_LW,     1'b1, E_FLT,    "ill_sticky");
        check("ill_fault", 32'(fault),      32'd1);
        check("ill_code",  32'(faultCode),  32'd1);
        check("ill_cnt",   32'(instrCount), 32'd0);

        // BNE: legal only with the option enabled
        do_reset();
        cyc(OP_BNE, 1'b1, E_FETCHR, "bne_fetch");
        cyc(OP_BNE, 1'b1, E_DEC,    "bne_dec");
`ifdef MULTICYCLE_CTRL_BNE_EN
        cyc(OP_BNE, 1'b1, E_BNE, "bne_exec");
        check("bne_cnt",   32'(instrCount), 32'd1);
        check("bne_fault", 32'(fault),      32'd0);
`else
        cyc(OP_BNE, 1'b1, E_FLT, "bne_flt");
        check("bne_code", 32'(faultCode),  32'd1);
        check("bne_cnt",  32'(instrCount), 32'd0);
`endif

        // Retire counter wraps from all-ones to zero
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(OP_J, 1'b1, E_FETCHR, "wrap_fetch");
            cyc(OP_J, 1'b1, E_DEC,    "wrap_dec");
            cyc(OP_J, 1'b1, E_JMP,    "wrap_jmp");
            if (i == 14) check("wrap_max", 32'(instrCount), 32'd15);
        end
        check("wrap_zero", 32'(instrCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle control decoder.
- Sequences each MIPS instruction over 3-5 states and stalls on a variable-latency memory via a ready handshake.
- Detects illegal opcodes and memory timeouts, and counts retired instructions.
- Sits between the instruction register opcode field and the shared-memory multicycle datapath.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles tolerated in a memory wait state; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
op  input  opcode_type (6)  opcode field from the instruction register
memReady  input  1  memory has completed the current access this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if ALU zero
branchNe  output  1  invert zero sense for pcWriteCond
iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  instruction register load
memToReg  output  1  register write-data select: 1 = MDR
regDst  output  1  destination register: 1 = rd, 0 = rt
regWrite  output  1  register file write
aluSrcA  output  1  0 = PC, 1 = register A
aluSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
aluOp  output  2  00 add, 01 sub, 10 funct
pcSrc  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
fault  output  1  sticky error flag
faultCode  output  2  00 none, 01 illegal opcode, 10 memory timeout
instrCount  output  CNT_W  retired-instruction count, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; it forces state FETCH, wait counter 0, instrCount 0, fault 0, faultCode 00.
- Strobes during reset: while rst is high, all write/request strobes are forced 0. These are pcWrite, pcWriteCond, memRead, memWrite, irWrite and regWrite.
- Default outputs: every output not listed for a state is 0. Muxes never drive X.
- FETCH:
  - Asserts memRead, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite and pcWrite are asserted only in the cycle memReady=1; that cycle also moves to DECODE.
  - Otherwise stays in FETCH.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Transitions by opcode:
  - LW, SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BEQ
  - J -> JMP
  - anything else -> FAULT with code 01
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: memRead, iorD=1. Waits for memReady, then goes to MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1, then FETCH (retire).
- MEMWR: memWrite, iorD=1. Waits for memReady, then FETCH (retire).
  - memWrite stays asserted, with a stable address, until the memReady cycle.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10, then ALUWB.
- ALUWB: regDst=1, memToReg=0, regWrite=1, then FETCH (retire).
- BEQ: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcWriteCond=1, then FETCH (retire).
- JMP: pcSrc=10, pcWrite=1, then FETCH (retire).
- FAULT: all strobes 0. Terminal until reset. fault=1, and faultCode holds the first cause.
- Instruction latency: FETCH+DECODE = 2 cycles with zero wait states. Totals with zero wait states:
  - J and BEQ: 3 cycles
  - R-type and SW: 4 cycles
  - LW: 5 cycles
- Wait counter:
  - Counts consecutive memReady=0 cycles in FETCH, MEMRD or MEMWR, and clears on every state change.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT while memReady=0, the next state is FAULT with code 10.
  - memReady=1 on exactly that cycle wins: the normal transition is taken.
- memReady outside the wait states is ignored.
- instrCount increments by 1 on each retiring transition and wraps from all-ones to 0.
- Reset asserted mid-instruction aborts immediately. No partial strobe is issued after rst rises.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN
- Defined: DECODE maps OP_BNE to state BNE. BNE drives the same outputs as BEQ plus branchNe=1, then retires.
- Undefined: OP_BNE is illegal (fault code 01) and branchNe is tied 0.

Decomposition:
- types package additions:
  - ctrl_state_type enum
  - fault_code_type enum
  - OP_BNE opcode constant
  - named constants for the aluOp, aluSrcB and pcSrc encodings
- One sub-module: mem_wait_timer. It holds the parametrised saturating counter with clear, enable and expired, and handles MEM_TIMEOUT=0.

Test Plan:
1. LW with memReady tied 1 -> irWrite pulses in cycle 0, regWrite+memToReg in cycle 4, instrCount 0->1.
2. SW with memReady low 3 cycles in MEMWR -> memWrite and iorD held 4 cycles, no FAULT, retire on the ready cycle.
3. MEM_TIMEOUT=4, memReady held 0 in FETCH -> FAULT after 4 wait cycles, faultCode=10, strobes 0; rst clears to FETCH.
4. Opcode 6'b111111 in DECODE -> FAULT, faultCode=01, instrCount unchanged; a later memReady has no effect.
5. Sequence R-type, BEQ, J -> regDst=1/regWrite in ALUWB, pcWriteCond with pcSrc=01, pcWrite with pcSrc=10; instrCount=3.
6. BNE with the macro defined -> pcWriteCond=1, branchNe=1. Without the macro -> faultCode=01.
7. rst pulsed during MEMRD wait -> strobes drop the same cycle, and after release the state is FETCH with instrCount=0.
